// File: rtl/rle_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rle_decode
//  Description : Run-length decompressor. Reads {count, value} byte pairs
//                from SRAM port A, expands each pair into `count` copies of
//                `value`, writes the plaintext back through the same port
//                and reports the decoded length.
//  Revision    : 1.0 - initial release
// ============================================================================
module rle_decode (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_size,
    input  logic [31:0] message_addr,
    output logic [31:0] message_size,
    output logic        done,
    output logic        error,
    output logic        port_A_clk,
    output logic [15:0] port_A_addr,
    output logic        port_A_we,
    output logic [31:0] port_A_data_in,
    input  logic [31:0] port_A_data_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DECODE  = 3'd3,
        S_EXPAND  = 3'd4,
        S_WRITE   = 3'd5,
        S_FLUSH   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Only the low 16 address bits ever reach the SRAM, so only those are kept.
    logic [15:0] r_rle_addr;
    logic [15:0] r_msg_addr;
    logic [31:0] r_rle_size;
    logic [31:0] r_message_size;
    logic        r_error;
    logic [31:0] r_in_byte;     // index of the next input byte to consume
    logic [13:0] r_out_word;    // wraps with the 16-bit byte address
    logic [31:0] r_in_buf;
    logic [31:0] r_out_buf;
    logic [7:0]  r_count;
    logic [7:0]  r_value;

    logic        w_accept;
    logic [7:0]  w_in_byte_val;
    logic [31:0] w_in_byte_nxt;
    logic [1:0]  w_slot;
    logic [7:0]  w_count_dec;
    logic [15:0] w_rd_addr;
    logic [15:0] w_wr_addr;

    // Address bits that are dropped on purpose (alignment and 16-bit window).
    wire w_unused = &{1'b0, rle_addr[31:16], rle_addr[1:0],
                      message_addr[31:16], message_addr[1:0]};

    assign w_accept      = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_in_byte_val = r_in_buf[{r_in_byte[1:0], 3'b000} +: 8];
    assign w_in_byte_nxt = r_in_byte + 32'd1;
    assign w_slot        = r_message_size[1:0];
    assign w_count_dec   = r_count - 8'd1;
    assign w_rd_addr     = r_rle_addr + {r_in_byte[15:2], 2'b00};
    assign w_wr_addr     = r_msg_addr + {r_out_word, 2'b00};

    assign port_A_clk    = clk;
    assign message_size  = r_message_size;
    assign error         = r_error;
    assign done          = (r_state == S_DONE);

    // Where to go once the byte at index idx-1 is fully handled: end of
    // stream flushes, a word boundary refills the input buffer.
    function automatic state_t f_continue(input logic [31:0] idx,
                                          input logic [31:0] size);
        if (idx == size)
            return S_FLUSH;
        else if (idx[1:0] == 2'b00)
            return S_FETCH;
        else
            return S_DECODE;
    endfunction

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and SRAM port drive
    always_comb begin
        w_state_nxt    = r_state;
        port_A_addr    = 16'h0000;
        port_A_we      = 1'b0;
        port_A_data_in = 32'h0000_0000;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start)
                    w_state_nxt = (rle_size == 32'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                port_A_addr = w_rd_addr;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (r_in_byte[0] && (r_count != 8'd0))
                    w_state_nxt = S_EXPAND;
                else
                    w_state_nxt = f_continue(w_in_byte_nxt, r_rle_size);
            end
            S_EXPAND: begin
                if (w_slot == 2'd3)
                    w_state_nxt = S_WRITE;
                else if (w_count_dec == 8'd0)
                    w_state_nxt = f_continue(r_in_byte, r_rle_size);
                else
                    w_state_nxt = S_EXPAND;
            end
            S_WRITE: begin
                port_A_we      = 1'b1;
                port_A_addr    = w_wr_addr;
                port_A_data_in = r_out_buf;
                w_state_nxt    = (r_count != 8'd0) ? S_EXPAND
                                                   : f_continue(r_in_byte, r_rle_size);
            end
            S_FLUSH: begin
                // Unused bytes are already zero because the buffer is
                // cleared after every full-word write.
                port_A_we      = (w_slot != 2'd0);
                port_A_addr    = w_wr_addr;
                port_A_data_in = r_out_buf;
                w_state_nxt    = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: job latch, input buffer, byte decode and output assembly
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rle_addr     <= 16'h0000;
            r_msg_addr     <= 16'h0000;
            r_rle_size     <= 32'd0;
            r_message_size <= 32'd0;
            r_error        <= 1'b0;
            r_in_byte      <= 32'd0;
            r_out_word     <= 14'd0;
            r_in_buf       <= 32'h0000_0000;
            r_out_buf      <= 32'h0000_0000;
            r_count        <= 8'd0;
            r_value        <= 8'd0;
        end else if (w_accept) begin
            r_rle_addr     <= {rle_addr[15:2], 2'b00};
            r_msg_addr     <= {message_addr[15:2], 2'b00};
            r_rle_size     <= rle_size;
            r_message_size <= 32'd0;
            r_error        <= 1'b0;
            r_in_byte      <= 32'd0;
            r_out_word     <= 14'd0;
            r_out_buf      <= 32'h0000_0000;
            r_count        <= 8'd0;
            r_value        <= 8'd0;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    r_in_buf <= port_A_data_out;
                end
                S_DECODE: begin
                    r_in_byte <= w_in_byte_nxt;
                    if (!r_in_byte[0]) begin
                        r_count <= w_in_byte_val;
                        // A count byte that ends the stream has no partner.
                        if (w_in_byte_nxt == r_rle_size)
                            r_error <= 1'b1;
                    end else begin
                        r_value <= w_in_byte_val;
                    end
                end
                S_EXPAND: begin
                    r_out_buf[{w_slot, 3'b000} +: 8] <= r_value;
                    r_message_size <= r_message_size + 32'd1;
                    r_count        <= w_count_dec;
                end
                S_WRITE: begin
                    r_out_word <= r_out_word + 14'd1;
                    r_out_buf  <= 32'h0000_0000;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rle_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rle_decode
//  Description : Self-checking bench for rle_decode with a behavioural
//                synchronous-read SRAM and a write log.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rle_decode;

    logic        clk;
    logic        nreset;
    logic        start;
    logic [31:0] rle_addr;
    logic [31:0] rle_size;
    logic [31:0] message_addr;
    logic [31:0] message_size;
    logic        done;
    logic        error;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic        port_A_we;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;

    int n_checks;
    int n_fail;

    // SRAM model, write log and access counter
    logic [31:0] mem [0:16383];
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    logic [15:0] wr_addr_log [0:63];
    logic [31:0] wr_data_log [0:63];
    int          wr_cnt;
    int          acc_cnt;

    typedef struct {
        logic [31:0] rle_addr;
        logic [31:0] rle_size;
        logic [31:0] msg_addr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_size;
        logic        exp_err;
        int          exp_nwr;
        logic [15:0] exp_a0;
        logic [31:0] exp_d0;
        logic [15:0] exp_a1;
        logic [31:0] exp_d1;
    } vec_t;

    vec_t vecs [0:6];

    rle_decode u_dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .message_addr    (message_addr),
        .message_size    (message_size),
        .done            (done),
        .error           (error),
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        wr_cnt  = 0;
        acc_cnt = 0;
    end

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr[15:2]] <= ld_data;
        else if (port_A_we)
            mem[port_A_addr[15:2]] <= port_A_data_in;
        port_A_data_out <= mem[port_A_addr[15:2]];
        if (port_A_we) begin
            wr_addr_log[wr_cnt % 64] <= port_A_addr;
            wr_data_log[wr_cnt % 64] <= port_A_data_in;
            wr_cnt <= wr_cnt + 1;
        end
        if (port_A_we || (port_A_addr != 16'h0000))
            acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int base;
        int cyc;
        load_word(v.rle_addr[15:0], v.w0);
        load_word(v.rle_addr[15:0] + 16'd4, v.w1);
        @(negedge clk);
        rle_addr     = v.rle_addr;
        rle_size     = v.rle_size;
        message_addr = v.msg_addr;
        start        = 1'b1;
        base         = wr_cnt;
        @(negedge clk);
        start = 1'b0;
        if (v.rle_size != 32'd0)
            check($sformatf("v%0d done_low_after_start", id), {31'd0, done}, 32'd0);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d done_within_budget", id), {31'd0, done}, 32'd1);
        check($sformatf("v%0d message_size", id), message_size, v.exp_size);
        check($sformatf("v%0d error", id), {31'd0, error}, {31'd0, v.exp_err});
        check($sformatf("v%0d write_count", id), wr_cnt - base, v.exp_nwr);
        if (v.exp_nwr > 0 && wr_cnt - base > 0) begin
            check($sformatf("v%0d wr0_addr", id), {16'd0, wr_addr_log[base % 64]}, {16'd0, v.exp_a0});
            check($sformatf("v%0d wr0_data", id), wr_data_log[base % 64], v.exp_d0);
        end
        if (v.exp_nwr > 1 && wr_cnt - base > 1) begin
            check($sformatf("v%0d wr1_addr", id), {16'd0, wr_addr_log[(base + 1) % 64]}, {16'd0, v.exp_a1});
            check($sformatf("v%0d wr1_data", id), wr_data_log[(base + 1) % 64], v.exp_d1);
        end
    endtask

    initial begin
        int acc_base;
        int wr_base;
        n_checks     = 0;
        n_fail       = 0;
        nreset       = 1'b0;
        start        = 1'b0;
        rle_addr     = 32'd0;
        rle_size     = 32'd0;
        message_addr = 32'd0;
        ld_en        = 1'b0;
        ld_addr      = 16'd0;
        ld_data      = 32'd0;

        //           rle_addr      size   msg_addr       w0            w1            size  err nwr a0        d0            a1        d1
        vecs[0] = '{32'h0000_0100, 32'd4, 32'h0000_0200, 32'hAA03_BB01, 32'h0000_0000, 32'd4, 1'b0, 1, 16'h0200, 32'hAAAA_AABB, 16'h0000, 32'h0};
        vecs[1] = '{32'h0000_0100, 32'd2, 32'h0000_0200, 32'hDEAD_1105, 32'h0000_0000, 32'd5, 1'b0, 2, 16'h0200, 32'h1111_1111, 16'h0204, 32'h0000_0011};
        vecs[2] = '{32'h0000_0100, 32'd4, 32'h0000_0200, 32'h3302_2200, 32'h0000_0000, 32'd2, 1'b0, 1, 16'h0200, 32'h0000_3333, 16'h0000, 32'h0};
        vecs[3] = '{32'h0000_0100, 32'd3, 32'h0000_0200, 32'hFF07_4402, 32'h0000_0000, 32'd2, 1'b1, 1, 16'h0200, 32'h0000_4444, 16'h0000, 32'h0};
        vecs[4] = '{32'h0000_0100, 32'd0, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 32'd0, 1'b0, 0, 16'h0000, 32'h0,          16'h0000, 32'h0};
        vecs[5] = '{32'h0000_0402, 32'd6, 32'h0000_0800, 32'h2002_1001, 32'hEEEE_3001, 32'd4, 1'b0, 1, 16'h0800, 32'h3020_2010, 16'h0000, 32'h0};
        vecs[6] = '{32'h0000_0100, 32'd2, 32'h0001_FFFF, 32'h0000_7706, 32'h0000_0000, 32'd6, 1'b0, 2, 16'hFFFC, 32'h7777_7777, 16'h0000, 32'h0000_7777};

        // Reset state
        #1;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_message_size", message_size, 32'd0);
        check("reset_we", {31'd0, port_A_we}, 32'd0);
        check("reset_addr", {16'd0, port_A_addr}, 32'd0);
        check("reset_data_in", port_A_data_in, 32'd0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("port_A_clk_follows_clk", {31'd0, port_A_clk}, {31'd0, clk});

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], i);

        // Empty frame: done one cycle after start, no SRAM traffic
        @(negedge clk);
        rle_size = 32'd0;
        rle_addr = 32'h0000_0100;
        start    = 1'b1;
        acc_base = acc_cnt;
        @(negedge clk);
        nreset = 1'b0;
        #1;
        nreset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("empty_done_one_cycle", {31'd0, done}, 32'd1);
        check("empty_message_size", message_size, 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("empty_no_access", acc_cnt - acc_base, 32'd0);

        // Reset in the middle of a long expansion
        load_word(16'h0300, 32'h0000_55C8);
        @(negedge clk);
        rle_addr     = 32'h0000_0300;
        rle_size     = 32'd2;
        message_addr = 32'h0000_0600;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_error", {31'd0, error}, 32'd0);
        check("midrst_message_size", message_size, 32'd0);
        check("midrst_we", {31'd0, port_A_we}, 32'd0);
        check("midrst_addr", {16'd0, port_A_addr}, 32'd0);
        check("midrst_data_in", port_A_data_in, 32'd0);
        wr_base = wr_cnt;
        repeat (4) @(negedge clk);
        check("midrst_no_writes", wr_cnt - wr_base, 32'd0);
        nreset = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rle_decode.md
# rle_decode

Run-length decompressor; the downstream counterpart of the frame RLE compressor. It reads a compressed frame of {count, value} byte pairs from the shared dual-port SRAM through port A and expands each pair into `count` copies of `value`. It writes the expanded plaintext back into the same SRAM, then reports the decoded length. Typically used to verify a compressed frame, or to reconstruct a frame before it is re-sent.

## Interface
- No parameters.
- `clk` — in, 1 — system clock.
- `nreset` — in, 1 — asynchronous, active-low reset.
- `start` — in, 1 — begin decoding; sampled only in IDLE or DONE.
- `rle_addr` — in, 32 — byte address of the compressed frame; word-aligned, bits [1:0] ignored.
- `rle_size` — in, 32 — compressed length in bytes.
- `message_addr` — in, 32 — byte address of the output region; word-aligned, bits [1:0] ignored.
- `message_size` — out, 32 — number of decoded bytes written.
- `done` — out, 1 — decode complete; held until the next accepted `start`.
- `error` — out, 1 — odd `rle_size` (a trailing count byte has no value byte); valid while `done` is high.
- `port_A_clk` — out, 1 — equals `clk`.
- `port_A_addr` — out, 16 — SRAM byte address, always a multiple of 4.
- `port_A_we` — out, 1 — write enable.
- `port_A_data_in` — out, 32 — SRAM write data.
- `port_A_data_out` — in, 32 — SRAM read data; valid the cycle after the address is presented.

## Operation
- Byte order is little-endian within a word: byte k occupies bits [8k+7:8k].
- The input stream is a sequence of pairs: count byte (even offset), then value byte (odd offset).
- States:
  - **IDLE** — waiting for `start`.
  - **FETCH** — present read address `rle_addr + 4*in_word`, `we`=0.
  - **CAPTURE** — latch `port_A_data_out` into the input buffer.
  - **DECODE** — consume one input byte per cycle.
  - **EXPAND** — append one copy of `value` per cycle to the output buffer.
  - **WRITE** — write the full output word.
  - **FLUSH** — write the partial final word.
  - **DONE**.
- Accepted `start`:
  - latch addresses and `rle_size`;
  - clear `message_size`, `error`, byte and word counters, and the output buffer;
  - deassert `done`;
  - go to FETCH, or straight to DONE if `rle_size`=0.
- DECODE:
  - even byte → latch as `count`;
  - odd byte → latch as `value`; go to EXPAND if `count`≠0, else stay in DECODE (a zero count emits nothing).
  - After the last input byte (byte index = `rle_size`) → FLUSH.
  - After byte 3 of the buffer → FETCH.
  - If `rle_size` is odd, the final count byte is dropped and `error`=1.
- EXPAND:
  - each cycle write `value` to output slot `out_byte[1:0]`, then increment `message_size` and decrement `count`;
  - slot 3 filled → WRITE;
  - `count` reaches 0 → return to DECODE, or to FETCH/FLUSH by the same rules as DECODE.
- WRITE:
  - `we`=1, `port_A_addr` = `message_addr + 4*out_word`, `data_in` = output buffer;
  - increment `out_word` and clear the buffer;
  - then resume EXPAND if `count`≠0, else the DECODE-continuation rule.
- FLUSH:
  - if `message_size[1:0]`≠0, write the partial word with unused bytes zero;
  - go to DONE.
- DONE: `done`=1; `message_size` and `error` stable; a new `start` restarts.
- Width rules:
  - `port_A_addr` is the low 16 bits of the computed address; it wraps modulo 2^16 with no flag.
  - `message_size` wraps modulo 2^32.
  - Overlap of input and output regions is not detected; the caller guarantees disjoint regions.

## Timing
- Reset values: `done`=0, `error`=0, `message_size`=0, `port_A_we`=0, `port_A_addr`=0, `port_A_data_in`=0; state=IDLE.
- Reset mid-operation aborts immediately and returns to IDLE; no further writes are issued.
- `port_A_we` is high only in WRITE and FLUSH, for exactly one cycle per word.
- Read latency is 1 cycle: address in FETCH (cycle N), data latched in CAPTURE (cycle N+1).
- Per input word: 2 cycles fetch, up to 4 cycles decode, plus 1 cycle per output byte and 1 per output word.
- `start` is ignored outside IDLE/DONE. `start` held high in DONE restarts every time DONE is reached.
- `done` rises the cycle after the FLUSH cycle. For `rle_size`=0 it rises 1 cycle after `start`.

## Test plan
- Input word 0xAA03_BB01 at 0x100, `rle_size`=4 (pairs {1,0xBB},{3,0xAA}) → single write 0xAAAAAABB to `message_addr`; `message_size`=4, `error`=0.
- Pair {5,0x11}, `rle_size`=2 → writes 0x11111111, then 0x00000011; `message_size`=5.
- Pairs {0,0x22},{2,0x33} → zero-count pair emits nothing; write 0x00003333; `message_size`=2.
- `rle_size`=3, bytes {2,0x44,7} → write 0x00004444; `message_size`=2, `error`=1.
- `rle_size`=0 → no SRAM accesses; `done`=1 one cycle after `start`; `message_size`=0.
- Assert `nreset` low mid-EXPAND → all outputs return to reset values immediately; a later `start` decodes correctly from scratch.
